// File: rtl/usb_bridge_pkg.sv
// Shared constants for the USB stream bridge: status/control bit positions and the
// value returned by a read of an empty RX FIFO.
package usb_bridge_pkg;

  localparam int unsigned STA_RX_EMPTY = 16;
  localparam int unsigned STA_TX_FULL  = 17;
  localparam int unsigned STA_OVR      = 18;

  localparam int unsigned CTL_FLUSH    = 0;
  localparam int unsigned CTL_CLR_OVR  = 1;

  localparam logic [31:0] EMPTY_READ   = 32'hFFFF_FFFF;

endpackage

// File: rtl/stream_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers, synchronous flush and fill level.
// DEPTH must be a power of two (>= 2).
module stream_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [WIDTH-1:0]         head_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic             do_push, do_pop;

  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign level_o = wptr_q - rptr_q;
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  // A pop frees the head slot in the same edge, so a full FIFO may still accept a push.
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && (!full_o || do_pop) && !flush_i;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PW'(1);
      if (do_pop)  rptr_d = rptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/usb_stream_bridge.sv
// Register-bus to USB CDC byte-stream bridge with RX/TX FIFOs, status word and flush.
// Define USB_BRIDGE_BLOCKING_READ_EN to stall CPU reads of an empty RX FIFO.
module usb_stream_bridge
  import usb_bridge_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned RX_DEPTH = 16,
  parameter int unsigned TX_DEPTH = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              reg_dat_we,
  input  logic              reg_dat_re,
  input  logic [31:0]       reg_dat_di,
  output logic [31:0]       reg_dat_do,
  output logic              reg_dat_wait,
  input  logic              reg_sta_we,
  input  logic [31:0]       reg_sta_di,
  output logic [31:0]       reg_sta_do,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready
);

  localparam int unsigned RX_PW = $clog2(RX_DEPTH) + 1;
  localparam int unsigned TX_PW = $clog2(TX_DEPTH) + 1;

  logic              flush, clr_ovr;
  logic              tx_push, tx_pop, tx_full, tx_empty;
  logic              rx_push, rx_pop, rx_full, rx_empty;
  logic [RX_PW-1:0]  rx_level;
  logic [TX_PW-1:0]  tx_level;
  logic [DATA_W-1:0] rx_head;
  logic              ovr_q, ovr_d;
  logic              unused_di;

  assign flush   = reg_sta_we && reg_sta_di[CTL_FLUSH];
  assign clr_ovr = reg_sta_we && reg_sta_di[CTL_CLR_OVR];

`ifdef USB_BRIDGE_BLOCKING_READ_EN
  assign reg_dat_wait = (reg_dat_we && tx_full) || (reg_dat_re && rx_empty);
`else
  assign reg_dat_wait = reg_dat_we && tx_full;
`endif

  assign tx_push  = reg_dat_we && !reg_dat_wait;
  assign tx_valid = !tx_empty;
  assign tx_pop   = tx_valid && tx_ready;

  // rx_ready is deliberately independent of a same-cycle CPU pop.
  assign rx_ready = !rx_full;
  assign rx_push  = rx_valid && rx_ready;
  assign rx_pop   = reg_dat_re && !reg_dat_wait && !rx_empty;

  assign reg_dat_do = rx_empty ? EMPTY_READ : 32'(rx_head);

  // Upper data bits and unused control bits are intentionally ignored.
  assign unused_di = ^{reg_dat_di, reg_sta_di};

  always_comb begin
    reg_sta_do               = '0;
    reg_sta_do[7:0]          = 8'(rx_level);
    reg_sta_do[15:8]         = 8'(tx_level);
    reg_sta_do[STA_RX_EMPTY] = rx_empty;
    reg_sta_do[STA_TX_FULL]  = tx_full;
    reg_sta_do[STA_OVR]      = ovr_q;
  end

  // Set has priority over a coincident software clear.
  always_comb begin
    ovr_d = ovr_q;
    if (clr_ovr)             ovr_d = 1'b0;
    if (rx_valid && rx_full) ovr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ovr_q <= 1'b0;
    end else begin
      ovr_q <= ovr_d;
    end
  end

  stream_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk_i   (clk),
    .rst_ni  (resetn),
    .push_i  (tx_push),
    .wdata_i (reg_dat_di[DATA_W-1:0]),
    .pop_i   (tx_pop),
    .flush_i (flush),
    .level_o (tx_level),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .head_o  (tx_data)
  );

  stream_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk_i   (clk),
    .rst_ni  (resetn),
    .push_i  (rx_push),
    .wdata_i (rx_data),
    .pop_i   (rx_pop),
    .flush_i (flush),
    .level_o (rx_level),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .head_o  (rx_head)
  );

endmodule

// File: tb/tb_usb_stream_bridge.sv
// Scoreboard bench for usb_stream_bridge: expected read data and TX bytes are queued at
// issue time and checked by a monitor whenever the DUT completes a read or a TX handshake.
module tb_usb_stream_bridge;

  logic        clk;
  logic        resetn;
  logic        reg_dat_we, reg_dat_re, reg_sta_we;
  logic [31:0] reg_dat_di, reg_sta_di;
  logic [31:0] reg_dat_do, reg_sta_do;
  logic        reg_dat_wait;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] rd_q [$];
  logic [31:0] tx_q [$];
  logic [31:0] mon_exp;

  usb_stream_bridge #(
    .DATA_W   (8),
    .RX_DEPTH (16),
    .TX_DEPTH (4)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .reg_dat_we   (reg_dat_we),
    .reg_dat_re   (reg_dat_re),
    .reg_dat_di   (reg_dat_di),
    .reg_dat_do   (reg_dat_do),
    .reg_dat_wait (reg_dat_wait),
    .reg_sta_we   (reg_sta_we),
    .reg_sta_di   (reg_sta_di),
    .reg_sta_do   (reg_sta_do),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  // Monitor: compare completed reads and TX handshakes against the queued expectations.
  always @(negedge clk) begin
    if (resetn) begin
      if (reg_dat_re && !reg_dat_wait) begin
        if (rd_q.size() == 0) begin
          n_vec = n_vec + 1;
          n_err = n_err + 1;
          $display("FAIL rd_unexpected: got %08h expected no read", reg_dat_do);
        end else begin
          mon_exp = rd_q.pop_front();
          check("rd_data", reg_dat_do, mon_exp);
        end
      end
      if (tx_valid && tx_ready) begin
        if (tx_q.size() == 0) begin
          n_vec = n_vec + 1;
          n_err = n_err + 1;
          $display("FAIL tx_unexpected: got %02h expected no byte", tx_data);
        end else begin
          mon_exp = tx_q.pop_front();
          check("tx_data", {24'h0, tx_data}, mon_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_read(input logic [31:0] exp);
    reg_dat_re = 1'b1;
    rd_q.push_back(exp);
    tick();
    reg_dat_re = 1'b0;
  endtask

  task automatic check_empty_read();
`ifdef USB_BRIDGE_BLOCKING_READ_EN
    check("empty_do", reg_dat_do, 32'hFFFF_FFFF);
`else
    cpu_read(32'hFFFF_FFFF);
`endif
  endtask

  task automatic cpu_write(input logic [7:0] v);
    reg_dat_we = 1'b1;
    reg_dat_di = {24'hA5A5A5, v};
    #1;
    check("wr_nowait", {31'h0, reg_dat_wait}, 32'h0);
    tx_q.push_back({24'h0, v});
    tick();
    reg_dat_we = 1'b0;
  endtask

  task automatic rx_send(input logic [7:0] v);
    rx_valid = 1'b1;
    rx_data  = v;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic sta_write(input logic [31:0] v);
    reg_sta_we = 1'b1;
    reg_sta_di = v;
    tick();
    reg_sta_we = 1'b0;
    reg_sta_di = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0;
    reg_dat_we = 0; reg_dat_re = 0; reg_sta_we = 0;
    reg_dat_di = '0; reg_sta_di = '0;
    tx_ready = 0; rx_valid = 0; rx_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dat_do", reg_dat_do, 32'hFFFF_FFFF);
    check("rst_sta", reg_sta_do, 32'h0001_0000);
    check("rst_rx_ready", {31'h0, rx_ready}, 32'h1);
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_wait", {31'h0, reg_dat_wait}, 32'h0);
    resetn = 1'b1;
    tick();
    check_empty_read();

    // RX path ordering
    rx_send(8'h41); rx_send(8'h42); rx_send(8'h43);
    check("rx_lvl3", reg_sta_do, 32'h0000_0003);
    cpu_read(32'h41); cpu_read(32'h42); cpu_read(32'h43);
    check_empty_read();

    // TX fill and stall release
    cpu_write(8'h10); cpu_write(8'h11); cpu_write(8'h12); cpu_write(8'h13);
    check("tx_full_sta", reg_sta_do, 32'h0003_0400);
    reg_dat_we = 1'b1;
    reg_dat_di = 32'h0000_0014;
    #1;
    check("stall_wait0", {31'h0, reg_dat_wait}, 32'h1);
    tx_q.push_back(32'h14);
    tick();
    check("stall_wait1", {31'h0, reg_dat_wait}, 32'h1);
    tx_ready = 1'b1;
    #1;
    check("stall_no_ready_path", {31'h0, reg_dat_wait}, 32'h1);
    tick();
    tx_ready = 1'b0;
    #1;
    check("stall_release", {31'h0, reg_dat_wait}, 32'h0);
    tick();
    reg_dat_we = 1'b0;
    check("tx_refill_sta", reg_sta_do, 32'h0003_0400);
    tx_ready = 1'b1;
    repeat (4) tick();
    tx_ready = 1'b0;
    check("tx_drained", {31'h0, tx_valid}, 32'h0);

    // RX full, overrun sticky and clear
    rx_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rx_data = 8'h60 + 8'(i);
      tick();
    end
    check("rx_full_ready", {31'h0, rx_ready}, 32'h0);
    check("rx_full_sta", reg_sta_do, 32'h0000_0010);
    tick();
    rx_valid = 1'b0;
    check("ovr_set", reg_sta_do, 32'h0004_0010);
    cpu_read(32'h60);
    check("rx_ready_back", {31'h0, rx_ready}, 32'h1);
    check("ovr_hold", reg_sta_do, 32'h0004_000F);
    sta_write(32'h2);
    check("ovr_clr", reg_sta_do, 32'h0000_000F);
    for (int i = 1; i < 16; i++) cpu_read(32'h60 + 32'(i));
    check_empty_read();

    // Flush both FIFOs; a coincident RX push is discarded
    for (int i = 0; i < 5; i++) rx_send(8'h70 + 8'(i));
    cpu_write(8'h20); cpu_write(8'h21); cpu_write(8'h22);
    check("pre_flush", reg_sta_do, 32'h0000_0305);
    rx_valid = 1'b1;
    rx_data  = 8'h99;
    sta_write(32'h1);
    rx_valid = 1'b0;
    tx_q.delete();
    check("post_flush", reg_sta_do, 32'h0001_0000);
    check("flush_tx_valid", {31'h0, tx_valid}, 32'h0);
    check_empty_read();

    // Asynchronous reset between clock edges
    rx_send(8'h31); rx_send(8'h32);
    check("pre_areset", reg_sta_do, 32'h0000_0002);
    resetn = 1'b0;
    #2;
    check("areset_sta", reg_sta_do, 32'h0001_0000);
    check("areset_do", reg_dat_do, 32'hFFFF_FFFF);
    #2;
    resetn = 1'b1;
    tick();

`ifdef USB_BRIDGE_BLOCKING_READ_EN
    reg_dat_re = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      check("blk_wait", {31'h0, reg_dat_wait}, 32'h1);
      tick();
    end
    rd_q.push_back(32'h55);
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    tick();
    rx_valid = 1'b0;
    #1;
    check("blk_release", {31'h0, reg_dat_wait}, 32'h0);
    tick();
    reg_dat_re = 1'b0;
    check("blk_level", reg_sta_do, 32'h0001_0000);
`endif

    tick();
    check("rd_q_drained", rd_q.size(), 32'h0);
    check("tx_q_drained", tx_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
